clock_gate_request_fsm: RTL and testbench
=========================================

# clock_gate_request_fsm

Always-on controller that sits directly upstream of the hard-macro clock gate. It decides when a gated clock domain should run, and drives the gate's asynchronous enable request with a four-phase handshake. The gate's asynchronous acknowledge comes back to this block through an internal synchronizer. Gating is automatic after a programmable idle period, and wake-up is on request.

## Interface
Parameters:
- IDLE_CYCLES, 64, consecutive idle cycles in ON before gating off; legal range ≥1.
- SYNC_STAGES, 2, flops in the enable_ack synchronizer; legal range ≥2.
- ACK_TIMEOUT, 256, cycles waited for an ack edge before flagging an error; legal range ≥SYNC_STAGES+2.

Ports:
- clock  in  1  always-on clock (ungated side).
- reset  in  1  synchronous, active-high reset.
- activity  in  1  gated-domain busy indication; level, synchronous to clock.
- wake_req  in  1  level request to have the gated clock running.
- force_on  in  1  keeps the clock running and inhibits idle gating.
- gate_enable  out  1  registered enable request to the gate's async enable input.
- enable_ack  in  1  asynchronous acknowledge from the gate; synchronized internally.
- clock_on  out  1  high only in state ON; the gated clock is confirmed running.
- busy  out  1  high in WAIT_ON or WAIT_OFF, i.e. a handshake is in flight.
- ack_timeout_err  out  1  sticky; set when a handshake exceeds ACK_TIMEOUT.
- clear_err  in  1  clears ack_timeout_err.

## Operation
- ack_s is enable_ack after SYNC_STAGES flops. All decisions use ack_s.
- The block has four states: OFF, WAIT_ON, ON, WAIT_OFF.
- Reset state: OFF, with gate_enable=0, clock_on=0, busy=0, ack_timeout_err=0, and the idle and timeout counters at 0.
- wake = wake_req | force_on | activity.
- OFF → WAIT_ON when wake=1. gate_enable goes to 1 in the same registered transition.
- WAIT_ON → ON when ack_s=1. gate_enable stays 1.
- ON: the idle counter increments each cycle that wake=0 and clears to 0 on any cycle that wake=1.
- ON → WAIT_OFF when the idle counter is IDLE_CYCLES-1 and wake=0. gate_enable goes to 0, and the idle counter clears.
- WAIT_OFF → OFF when ack_s=0.
- Four-phase rules:
  - gate_enable never changes while busy=1.
  - A new request is issued only after the previous ack edge has been seen.
  - A handshake in flight is never aborted. If wake=1 during WAIT_OFF, the block completes the transition to OFF, then goes to WAIT_ON on the next cycle.
  - If activity drops during WAIT_ON, the block still completes the transition to ON and restarts the idle count there.
- Timeout:
  - The timeout counter runs only in WAIT_ON and WAIT_OFF, and clears on entry to either state.
  - When it reaches ACK_TIMEOUT-1, ack_timeout_err is set. The block stays in the wait state; there is no forced recovery.
  - The counter saturates at that value.
- clear_err=1 clears ack_timeout_err next cycle. If clear_err and a new timeout occur in the same cycle, set wins.
- Reset mid-handshake returns the block to OFF with gate_enable=0. The gate then releases by itself, and the stale ack_s=1 is ignored in OFF.
- If ack_s is already 1 on entry to WAIT_ON, the block proceeds to ON on the next cycle.
- Counter widths are $clog2(IDLE_CYCLES) and $clog2(ACK_TIMEOUT), each with a minimum of 1 bit. No wrap is possible because the counters saturate or clear.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Wake latency:
  - wake rising in OFF at cycle N gives gate_enable=1 and busy=1 at N+1.
  - An ack edge arriving at cycle M appears as ack_s by cycle M+SYNC_STAGES.
  - clock_on=1 follows one cycle after ack_s=1 is sampled.
- Gating latency: with wake low from cycle N onward in ON, gate_enable falls at N+IDLE_CYCLES.
- Round trip with an immediate ack: OFF→ON takes 1+SYNC_STAGES+1 cycles, which is 4 cycles at the default SYNC_STAGES.

## Test plan
- **Reset then wake.** Assert reset, then release it. Pulse wake_req high for 1 cycle. The ack model raises enable_ack 3 cycles after gate_enable.
  - Required: gate_enable=1 at +1, and busy=1 until ON.
  - Required: clock_on=1 exactly 1+3+2+1 cycles after the pulse, with ack_timeout_err=0.
- **Idle gating (IDLE_CYCLES=8).** From ON, drop all wake sources.
  - Required: gate_enable falls exactly 8 cycles later.
  - Required: a single activity pulse at idle count 5 delays the fall by 6 cycles.
- **Wake during WAIT_OFF.** Assert wake_req 1 cycle after gate_enable falls, with the ack dropping 4 cycles later.
  - Required: the state reaches OFF, then WAIT_ON on the next cycle (gate_enable back to 1).
  - Required: no gate_enable glitch while busy=1.
- **Timeout (ACK_TIMEOUT=16).** Hold enable_ack at 0 after a wake.
  - Required: ack_timeout_err rises 16 cycles after entry to WAIT_ON, and the block stays in WAIT_ON.
  - Then raise the ack. Required: ON is reached and the error stays set.
  - Then assert clear_err. Required: the error clears the next cycle.
- **force_on.** Hold force_on=1 in ON for 500 cycles. Required: gate_enable stays 1.
- **Reset mid-WAIT_ON.** Apply reset while enable_ack=1. Required: OFF with gate_enable=0 next cycle, and clock_on stays 0.

Source files
------------

// File: rtl/clock_gate_request_fsm.sv
// Purpose: decides when the gated domain runs; drives the clock gate's enable with a four-phase handshake.
// Latency: wake->gate_enable 1 cycle; ack->clock_on SYNC_STAGES+1 cycles; idle gating after IDLE_CYCLES quiet cycles.
// Backpressure: none; an in-flight handshake always completes before a new request, and a stalled one is flagged.
module clock_gate_request_fsm #(
    parameter int IDLE_CYCLES = 64,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic activity,
    input  logic wake_req,
    input  logic force_on,
    output logic gate_enable,
    input  logic enable_ack,
    output logic clock_on,
    output logic busy,
    output logic ack_timeout_err,
    input  logic clear_err
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        WAIT_ON  = 2'd1,
        ON       = 2'd2,
        WAIT_OFF = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [IW-1:0]          idle_cnt;
    logic [IW-1:0]          idle_cnt_n;
    logic [TW-1:0]          tmo_cnt;
    logic [TW-1:0]          tmo_cnt_n;
    logic                   wake;
    logic                   waiting;
    logic                   tmo_hit;

    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign wake    = wake_req | force_on | activity;
    assign waiting = (state == WAIT_ON) || (state == WAIT_OFF);
    assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

    // enable_ack is asynchronous to clock; nothing downstream looks at it before the last stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], enable_ack};
        end
    end

    always_comb begin
        state_n    = state;
        idle_cnt_n = idle_cnt;
        tmo_cnt_n  = '0;
        case (state)
            OFF: begin
                if (wake) state_n = WAIT_ON;
            end
            WAIT_ON: begin
                if (ack_s) state_n = ON;
            end
            ON: begin
                if (wake) begin
                    idle_cnt_n = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_n    = WAIT_OFF;
                    idle_cnt_n = '0;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            WAIT_OFF: begin
                if (!ack_s) state_n = OFF;
            end
            default: state_n = OFF;
        endcase
        // Saturating wait counter; outside the wait states it sits at zero, so entry always starts fresh.
        if (waiting) begin
            tmo_cnt_n = (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= OFF;
            idle_cnt        <= '0;
            tmo_cnt         <= '0;
            gate_enable     <= 1'b0;
            clock_on        <= 1'b0;
            busy            <= 1'b0;
            ack_timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            idle_cnt    <= idle_cnt_n;
            tmo_cnt     <= tmo_cnt_n;
            gate_enable <= (state_n == WAIT_ON) || (state_n == ON);
            clock_on    <= (state_n == ON);
            busy        <= (state_n == WAIT_ON) || (state_n == WAIT_OFF);
            if (tmo_hit) begin
                ack_timeout_err <= 1'b1;
            end else if (clear_err) begin
                ack_timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_gate_request_fsm.sv
// Bench for clock_gate_request_fsm: directed scenarios plus randomized traffic,
// scored against a request/confirm handshake model of the gate controller.
module tb_clock_gate_request_fsm;

    localparam int IC = 8;
    localparam int SS = 2;
    localparam int AT = 16;

    logic clock      = 1'b0;
    logic reset      = 1'b1;
    logic activity   = 1'b0;
    logic wake_req   = 1'b0;
    logic force_on   = 1'b0;
    logic enable_ack = 1'b0;
    logic clear_err  = 1'b0;
    logic gate_enable;
    logic clock_on;
    logic busy;
    logic ack_timeout_err;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;   // 0: ack follows gate_enable after ack_dly cycles, 1: ack held low
    int ack_dly  = 3;

    typedef struct packed {
        logic ge;
        logic con;
        logic bsy;
        logic err;
    } exp_t;

    exp_t sb_q[$];
    logic gh[$];
    logic hq[$];

    clock_gate_request_fsm #(
        .IDLE_CYCLES(IC),
        .SYNC_STAGES(SS),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .activity       (activity),
        .wake_req       (wake_req),
        .force_on       (force_on),
        .gate_enable    (gate_enable),
        .enable_ack     (enable_ack),
        .clock_on       (clock_on),
        .busy           (busy),
        .ack_timeout_err(ack_timeout_err),
        .clear_err      (clear_err)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_on(input string name, input int lim);
        int n;
        n = 0;
        while (clock_on !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk(name, clock_on, 1'b1);
    endtask

    task automatic wait_off(input string name, input int lim);
        int n;
        n = 0;
        while ((gate_enable !== 1'b0 || busy !== 1'b0) && n < lim) begin
            tick();
            n++;
        end
        chk(name, gate_enable | busy, 1'b0);
    endtask

    // Gate macro: acknowledge mirrors the enable request after a programmable delay.
    initial begin
        for (int i = 0; i < 16; i++) gh.push_back(1'b0);
        forever begin
            @(negedge clock);
            gh.push_back(gate_enable);
            void'(gh.pop_front());
            if (ack_mode == 1) enable_ack = 1'b0;
            else               enable_ack = gh[gh.size() - 1 - ack_dly];
        end
    end

    // Reference: the controller as a requested level (req) and a confirmed level (conf).
    initial begin : ref_model
        logic m_req, m_conf, m_err, a_s, w, inflight;
        int   m_idle, m_wcnt;
        exp_t e;
        m_req = 0; m_conf = 0; m_err = 0; m_idle = 0; m_wcnt = 0;
        for (int i = 0; i < SS; i++) hq.push_back(1'b0);
        forever begin
            @(posedge clock);
            if (reset) begin
                m_req = 0; m_conf = 0; m_err = 0; m_idle = 0; m_wcnt = 0;
                hq.delete();
                for (int i = 0; i < SS; i++) hq.push_back(1'b0);
            end else begin
                a_s = hq.pop_front();
                hq.push_back(enable_ack);
                w = wake_req | force_on | activity;
                inflight = (m_req != m_conf);
                if (inflight && m_wcnt == AT - 1) m_err = 1'b1;
                else if (clear_err)               m_err = 1'b0;
                if (!inflight)          m_wcnt = 0;
                else if (m_wcnt < AT-1) m_wcnt++;
                if (inflight) begin
                    if (a_s == m_req) m_conf = m_req;
                end else if (!m_req) begin
                    if (w) m_req = 1'b1;
                end else if (w) begin
                    m_idle = 0;
                end else if (m_idle == IC - 1) begin
                    m_req = 1'b0;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
            e.ge  = m_req;
            e.con = m_req & m_conf;
            e.bsy = m_req ^ m_conf;
            e.err = m_err;
            sb_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({gate_enable, clock_on, busy, ack_timeout_err} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got ge=%b on=%b busy=%b err=%b, required ge=%b on=%b busy=%b err=%b",
                             $time, gate_enable, clock_on, busy, ack_timeout_err, e.ge, e.con, e.bsy, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        int lows;
        int dens;
        repeat (3) tick();
        chk("reset_gate_enable", gate_enable, 1'b0);
        chk("reset_clock_on", clock_on, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", ack_timeout_err, 1'b0);
        reset = 1'b0;

        // Reset then wake: one-cycle wake_req pulse, ack 3 cycles after the enable.
        tick();
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        chk("wake_gate_enable_p1", gate_enable, 1'b1);
        chk("wake_busy_p1", busy, 1'b1);
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("busy_until_on", busy, 1'b1);
            chk("clock_on_not_early", clock_on, 1'b0);
        end
        tick();
        chk("clock_on_at_p7", clock_on, 1'b1);
        chk("busy_clear_in_on", busy, 1'b0);
        chk("no_err_on_wake", ack_timeout_err, 1'b0);

        // Idle gating: no wake source since ON entry, so the enable falls 8 cycles later.
        for (int k = 8; k <= 14; k++) begin
            tick();
            chk("idle_hold", gate_enable, 1'b1);
        end
        tick();
        chk("idle_fall_8", gate_enable, 1'b0);
        wait_off("off_after_idle", 40);

        // Activity pulse at idle count 5 pushes the fall out by 6 cycles.
        ack_dly = 4;
        activity = 1'b1;
        wait_on("on_for_pulse", 40);
        tick();
        activity = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        activity = 1'b1;
        tick();
        activity = 1'b0;
        for (int k = 7; k <= 13; k++) begin
            tick();
            chk("pulse_hold", gate_enable, 1'b1);
        end
        tick();
        chk("pulse_fall_14", gate_enable, 1'b0);

        // Wake during WAIT_OFF: handshake completes to OFF, then re-requests.
        chk("wait_off_busy", busy, 1'b1);
        tick();
        wake_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            chk("wait_off_no_glitch", gate_enable, 1'b0);
            chk("wait_off_busy_hold", busy, 1'b1);
            if (k < 6) tick();
        end
        tick();
        chk("reached_off_ge", gate_enable, 1'b0);
        chk("reached_off_busy", busy, 1'b0);
        tick();
        chk("rewake_ge", gate_enable, 1'b1);
        chk("rewake_busy", busy, 1'b1);
        wake_req = 1'b0;
        wait_on("on_after_rewake", 40);
        wait_off("off_before_timeout", 60);

        // Timeout: ack held low after a wake.
        ack_mode = 1;
        tick();
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        chk("tmo_in_wait_on", busy, 1'b1);
        for (int k = 2; k <= 16; k++) tick();
        chk("err_not_early", ack_timeout_err, 1'b0);
        tick();
        chk("err_at_16", ack_timeout_err, 1'b1);
        chk("tmo_stays_busy", busy, 1'b1);
        chk("tmo_not_on", clock_on, 1'b0);
        tick();
        chk("tmo_still_waiting", busy, 1'b1);
        force_on = 1'b1;
        ack_mode = 0;
        wait_on("on_after_late_ack", 20);
        chk("err_sticky_in_on", ack_timeout_err, 1'b1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("err_cleared", ack_timeout_err, 1'b0);

        // force_on held in ON for 500 cycles.
        lows = 0;
        repeat (500) begin
            tick();
            if (gate_enable !== 1'b1) lows++;
        end
        chk_int("force_on_low_cycles", lows, 0);

        // Reset in WAIT_ON while the ack is already high.
        force_on = 1'b0;
        wait_off("off_before_reset_test", 60);
        ack_dly = 3;
        tick();
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        repeat (3) tick();
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_ge", gate_enable, 1'b0);
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_clock_on", clock_on, 1'b0);
        lows = 0;
        repeat (8) begin
            tick();
            if (clock_on !== 1'b0 || gate_enable !== 1'b0) lows++;
        end
        chk_int("stale_ack_ignored_cycles", lows, 0);

        // Randomized traffic, scored by the model.
        dens = 5;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       dens = 0;
                    1:       dens = 5;
                    default: dens = 30;
                endcase
                ack_mode = ($urandom_range(0, 99) < 15) ? 1 : 0;
                ack_dly  = $urandom_range(0, 5);
            end
            activity  = ($urandom_range(0, 99) < dens);
            wake_req  = ($urandom_range(0, 99) < dens / 3);
            if ($urandom_range(0, 99) < 1) force_on = ~force_on;
            clear_err = ($urandom_range(0, 99) < 3);
            reset     = ($urandom_range(0, 999) < 3);
            tick();
        end
        reset = 1'b0; activity = 1'b0; wake_req = 1'b0; force_on = 1'b0; clear_err = 1'b0;
        tick();
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
